// File: rtl/tl_line_master.sv
// TL-UH line master: one Get (8 AccessAckData beats) or one 8-beat PutFullData burst
// per command, a single transaction outstanding, completion held until consumed.
module tl_line_master #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned BEATS     = 8,
    parameter logic [3:0]  SOURCE_ID = 4'd0,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W*BEATS-1:0] req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_write,
    output logic [DATA_W*BEATS-1:0] resp_rdata,
    output logic                    resp_denied,
    output logic                    resp_error,
    output logic [2:0]              a_opcode,
    output logic [2:0]              a_param,
    output logic [2:0]              a_size,
    output logic [3:0]              a_source,
    output logic [ADDR_W-1:0]       a_address,
    output logic [7:0]              a_mask,
    output logic [DATA_W-1:0]       a_data,
    output logic                    a_valid,
    input  logic                    a_ready,
    input  logic [2:0]              d_opcode,
    input  logic [1:0]              d_param,
    input  logic [2:0]              d_size,
    input  logic [3:0]              d_source,
    input  logic [1:0]              d_sink,
    input  logic                    d_denied,
    input  logic [DATA_W-1:0]       d_data,
    input  logic                    d_corrupt,
    input  logic                    d_valid,
    output logic                    d_ready
);

    localparam int unsigned LINE_W = DATA_W * BEATS;
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam int unsigned BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    localparam logic [2:0] OP_GET       = 3'd4;
    localparam logic [2:0] OP_PUT_FULL  = 3'd0;
    localparam logic [2:0] OP_ACK       = 3'd0;
    localparam logic [2:0] OP_ACK_DATA  = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_REQ,
        S_GET_DATA,
        S_PUT_DATA,
        S_PUT_ACK,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [LINE_W-1:0]   rdata_q;
    logic                write_q;
    logic                denied_q;
    logic                error_q;
    logic [BW-1:0]       beat_cnt_q;
    logic [TW-1:0]       tmo_cnt_q;

    logic                in_d_wait;
    logic                d_fire;
    logic                d_bad;
    logic                tmo_hit;
    logic [2:0]          exp_d_op;
    logic [DATA_W-1:0]   put_beat;

    assign in_d_wait = (state_q == S_GET_DATA) || (state_q == S_PUT_ACK);
    assign d_fire    = in_d_wait && d_valid;
    assign exp_d_op  = (state_q == S_GET_DATA) ? OP_ACK_DATA : OP_ACK;
    assign d_bad     = (d_opcode != exp_d_op) || (d_source != SOURCE_ID);
    // Timeout fires on the TIMEOUT-th consecutive D-wait cycle with no beat offered.
    assign tmo_hit   = (TIMEOUT != 0) && in_d_wait && !d_valid && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = req_write ? S_PUT_DATA : S_GET_REQ;
                end
            end
            S_GET_REQ: begin
                if (a_ready) begin
                    state_d = S_GET_DATA;
                end
            end
            S_GET_DATA: begin
                if ((d_fire && (beat_cnt_q == LAST_BEAT)) || tmo_hit) begin
                    state_d = S_RESP;
                end
            end
            S_PUT_DATA: begin
                if (a_ready && (beat_cnt_q == LAST_BEAT)) begin
                    state_d = S_PUT_ACK;
                end
            end
            S_PUT_ACK: begin
                if (d_fire || tmo_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        put_beat = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (beat_cnt_q == BW'(i)) begin
                put_beat = wdata_q[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        req_ready  = 1'b0;
        a_valid    = 1'b0;
        d_ready    = 1'b0;
        resp_valid = 1'b0;
        a_opcode   = OP_GET;
        a_data     = '0;
        unique case (state_q)
            S_IDLE:     req_ready = 1'b1;
            S_GET_REQ:  a_valid   = 1'b1;
            S_GET_DATA: d_ready   = 1'b1;
            S_PUT_DATA: begin
                a_valid  = 1'b1;
                a_opcode = OP_PUT_FULL;
                a_data   = put_beat;
            end
            S_PUT_ACK:  d_ready    = 1'b1;
            S_RESP:     resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            write_q    <= 1'b0;
            denied_q   <= 1'b0;
            error_q    <= 1'b0;
            beat_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q     <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        wdata_q    <= req_wdata;
                        write_q    <= req_write;
                        rdata_q    <= '0;
                        denied_q   <= 1'b0;
                        error_q    <= 1'b0;
                        beat_cnt_q <= '0;
                        tmo_cnt_q  <= '0;
                    end
                end
                S_GET_REQ: begin
                    beat_cnt_q <= '0;
                    tmo_cnt_q  <= '0;
                end
                S_PUT_DATA: begin
                    tmo_cnt_q <= '0;
                    if (a_ready) begin
                        beat_cnt_q <= (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
                    end
                end
                S_GET_DATA, S_PUT_ACK: begin
                    if (d_fire) begin
                        tmo_cnt_q  <= '0;
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (d_bad) begin
                            error_q <= 1'b1;
                        end
                        if (d_denied || d_corrupt) begin
                            denied_q <= 1'b1;
                        end
                        if (state_q == S_GET_DATA) begin
                            for (int unsigned i = 0; i < BEATS; i++) begin
                                if (beat_cnt_q == BW'(i)) begin
                                    rdata_q[DATA_W*i +: DATA_W] <= d_data;
                                end
                            end
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        if (tmo_hit) begin
                            error_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign a_param     = '0;
    assign a_size      = 3'(OFF_W);
    assign a_source    = SOURCE_ID;
    assign a_address   = addr_q;
    assign a_mask      = '1;
    assign resp_write  = write_q;
    assign resp_rdata  = rdata_q;
    assign resp_denied = denied_q;
    assign resp_error  = error_q;

    logic unused_inputs;
    assign unused_inputs = ^{d_param, d_size, d_sink, req_addr[OFF_W-1:0]};

endmodule

// File: tb/tb_tl_line_master.sv
// Scoreboarded bench for tl_line_master: a TL-UH RAM responder model checks A beats,
// and a separate monitor checks each completion against the expected-response queue.
module tb_tl_line_master;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 64;
    localparam int unsigned NB = 8;
    localparam int unsigned LW = DW * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_wdata;
    logic          resp_valid, resp_ready, resp_write, resp_denied, resp_error;
    logic [LW-1:0] resp_rdata;
    logic [2:0]    a_opcode, a_param, a_size;
    logic [3:0]    a_source;
    logic [AW-1:0] a_address;
    logic [7:0]    a_mask;
    logic [DW-1:0] a_data;
    logic          a_valid, a_ready;
    logic [2:0]    d_opcode, d_size;
    logic [1:0]    d_param, d_sink;
    logic [3:0]    d_source;
    logic          d_denied, d_corrupt, d_valid, d_ready;
    logic [DW-1:0] d_data;

    always #5 clk = ~clk;

    tl_line_master #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .BEATS(NB),
        .SOURCE_ID(4'd0),
        .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_rdata(resp_rdata), .resp_denied(resp_denied), .resp_error(resp_error),
        .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .a_valid(a_valid), .a_ready(a_ready),
        .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
        .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt),
        .d_valid(d_valid), .d_ready(d_ready)
    );

    typedef struct {
        logic [2:0]  op;
        logic [63:0] addr;
        logic [63:0] data;
    } a_exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  src;
        logic        den;
        logic        cor;
        logic [63:0] data;
    } d_beat_t;

    typedef struct {
        logic          wr;
        logic [LW-1:0] rdata;
        logic          den;
        logic          err;
    } resp_t;

    a_exp_t  a_q[$];
    d_beat_t d_q[$];
    resp_t   r_q[$];

    logic [63:0] mem    [0:511];
    logic [63:0] shadow [0:511];

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    bit          stall_en    = 1'b0;
    bit          inj_mute    = 1'b0;
    int          inj_deny    = -1;
    int          inj_corrupt = -1;
    int          inj_badop   = -1;
    logic [3:0]  inj_ack_src = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // TL-UH RAM responder: observes handshakes at negedge, drives its outputs 1ns after posedge.
    initial begin
        a_exp_t  e;
        d_beat_t b;
        int      idx;
        int      put_cnt;
        int      d_stall;
        bit      prev_stall;
        logic [63:0] prev_data, prev_addr;
        logic [2:0]  prev_op;
        put_cnt = 0; d_stall = 0; prev_stall = 1'b0;
        prev_data = '0; prev_addr = '0; prev_op = '0;
        a_ready = 1'b0; d_valid = 1'b0;
        d_opcode = '0; d_param = '0; d_size = 3'd6; d_source = '0; d_sink = '0;
        d_denied = 1'b0; d_corrupt = 1'b0; d_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                a_q.delete();
                d_q.delete();
                put_cnt    = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("a_hold_valid", LW'(a_valid), LW'(1));
                    check("a_hold_data", LW'(a_data), LW'(prev_data));
                    check("a_hold_addr", LW'(a_address), LW'(prev_addr));
                    check("a_hold_opcode", LW'(a_opcode), LW'(prev_op));
                end
                prev_stall = a_valid && !a_ready;
                prev_data  = a_data;
                prev_addr  = a_address;
                prev_op    = a_opcode;
                if (d_valid && d_ready) begin
                    check("d_accept_state", LW'({a_valid, resp_valid, req_ready}), LW'(0));
                    void'(d_q.pop_front());
                end
                if (a_valid && a_ready) begin
                    check("a_const_fields", LW'({a_param, a_size, a_source, a_mask}),
                          LW'({3'd0, 3'd6, 4'd0, 8'hFF}));
                    if (a_q.size() == 0) begin
                        check("a_unexpected_beat", LW'(1), LW'(0));
                    end else begin
                        e = a_q.pop_front();
                        check("a_opcode", LW'(a_opcode), LW'(e.op));
                        check("a_address", LW'(a_address), LW'(e.addr));
                        check("a_data", LW'(a_data), LW'(e.data));
                    end
                    idx = int'(a_address[11:3]);
                    if (a_opcode == 3'd4) begin
                        if (!inj_mute) begin
                            for (int i = 0; i < NB; i++) begin
                                b.op   = (inj_badop == i) ? 3'd0 : 3'd1;
                                b.src  = 4'd0;
                                b.den  = (inj_deny == i);
                                b.cor  = (inj_corrupt == i);
                                b.data = mem[idx + i];
                                d_q.push_back(b);
                            end
                        end
                    end else begin
                        mem[idx + put_cnt] = a_data;
                        put_cnt++;
                        if (put_cnt == NB) begin
                            put_cnt = 0;
                            if (!inj_mute) begin
                                b.op = 3'd0; b.src = inj_ack_src; b.den = 1'b0;
                                b.cor = 1'b0; b.data = '0;
                                d_q.push_back(b);
                            end
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            a_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (d_q.size() > 0 && (!stall_en || d_stall >= 2 || $urandom_range(0, 2) != 0)) begin
                d_valid   = 1'b1;
                d_opcode  = d_q[0].op;
                d_source  = d_q[0].src;
                d_denied  = d_q[0].den;
                d_corrupt = d_q[0].cor;
                d_data    = d_q[0].data;
                d_stall   = 0;
            end else begin
                d_valid = 1'b0;
                d_stall = (d_q.size() > 0) ? d_stall + 1 : 0;
            end
        end
    end

    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp_ready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    // Completion monitor.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid && resp_ready) begin
                if (r_q.size() == 0) begin
                    check("resp_unexpected", LW'(1), LW'(0));
                end else begin
                    r = r_q.pop_front();
                    check("resp_write", LW'(resp_write), LW'(r.wr));
                    check("resp_denied", LW'(resp_denied), LW'(r.den));
                    check("resp_error", LW'(resp_error), LW'(r.err));
                    if (!r.wr) check("resp_rdata", resp_rdata, r.rdata);
                end
            end
        end
    end

    task automatic issue(input bit wr, input logic [63:0] addr, input logic [LW-1:0] wdata,
                         input logic [LW-1:0] exp_rd, input bit exp_den, input bit exp_err);
        a_exp_t a;
        resp_t  r;
        bit     fired = 1'b0;
        logic [63:0] line;
        line = {addr[63:6], 6'b0};
        if (wr) begin
            for (int i = 0; i < NB; i++) begin
                a.op = 3'd0; a.addr = line; a.data = wdata[DW*i +: DW];
                a_q.push_back(a);
                shadow[int'(line[11:3]) + i] = wdata[DW*i +: DW];
            end
        end else begin
            a.op = 3'd4; a.addr = line; a.data = '0;
            a_q.push_back(a);
        end
        r.wr = wr; r.rdata = exp_rd; r.den = exp_den; r.err = exp_err;
        r_q.push_back(r);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        for (int t = 0; t < 3000 && !fired; t++) begin
            @(negedge clk);
            if (req_ready) fired = 1'b1;
        end
        check("req_accepted", LW'(fired), LW'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            if (r_q.size() == 0 && req_ready) done = 1'b1;
        end
        check("drain_done", LW'(done), LW'(1));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] shadow_line(input logic [63:0] addr);
        logic [LW-1:0] v;
        for (int i = 0; i < NB; i++) v[DW*i +: DW] = shadow[int'(addr[11:6]) * NB + i];
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] wd1, rd3, wd;
        logic [63:0]   addr;
        int unsigned   t0;
        bit            seen;
        int            nbeats;
        for (int i = 0; i < 512; i++) begin
            mem[i]    = 64'(i);
            shadow[i] = 64'(i);
        end
        for (int i = 0; i < NB; i++) begin
            wd1[DW*i +: DW] = 64'h1000 + 64'(i);
            rd3[DW*i +: DW] = 64'(16 + i);
        end
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", LW'(req_ready), LW'(1));
        check("rst_handshake_outs", LW'({a_valid, d_ready, resp_valid}), LW'(0));
        check("rst_resp_fields", LW'({resp_write, resp_denied, resp_error}), LW'(0));
        check("rst_resp_rdata", resp_rdata, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed: line write, read-back, unaligned read of untouched line.
        issue(1'b1, 64'h40, wd1, '0, 1'b0, 1'b0);
        drain();
        issue(1'b0, 64'h40, '0, wd1, 1'b0, 1'b0);
        drain();
        issue(1'b0, 64'h87, '0, rd3, 1'b0, 1'b0);
        drain();

        // Error / denied injection.
        inj_deny = 3;
        issue(1'b0, 64'h40, '0, wd1, 1'b1, 1'b0);
        drain();
        inj_deny = -1; inj_corrupt = 0;
        issue(1'b0, 64'h80, '0, rd3, 1'b1, 1'b0);
        drain();
        inj_corrupt = -1; inj_badop = 5;
        issue(1'b0, 64'h80, '0, rd3, 1'b0, 1'b1);
        drain();
        inj_badop = -1; inj_ack_src = 4'd5;
        issue(1'b1, 64'h100, {8{64'hA5A5_0000_0000_0001}}, '0, 1'b0, 1'b1);
        drain();
        inj_ack_src = 4'd0;

        // Mixed traffic with stalls on every handshake.
        stall_en = 1'b1;
        for (int n = 0; n < 50; n++) begin
            addr = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < NB; i++) wd[DW*i +: DW] = {32'($urandom), 32'($urandom)};
                issue(1'b1, addr, wd, '0, 1'b0, 1'b0);
            end else begin
                issue(1'b0, addr, '0, shadow_line(addr), 1'b0, 1'b0);
            end
        end
        drain();
        stall_en = 1'b0;

        // Reset in the middle of a Put burst.
        issue(1'b1, 64'hFC0, wd1, '0, 1'b0, 1'b0);
        nbeats = 0;
        for (int t = 0; t < 100 && nbeats < 4; t++) begin
            @(negedge clk);
            if (a_valid && a_ready) nbeats++;
        end
        check("put_beats_before_rst", LW'(nbeats), LW'(4));
        @(posedge clk);
        #1;
        rst = 1'b1;
        void'(r_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_a_valid", LW'(a_valid), LW'(0));
        check("post_rst_resp_valid", LW'(resp_valid), LW'(0));
        check("post_rst_req_ready", LW'(req_ready), LW'(1));
        check("post_rst_d_ready", LW'(d_ready), LW'(0));
        @(posedge clk);
        #1;

        // Read with no D response: Get accepted next cycle, then 16 idle D cycles.
        inj_mute = 1'b1;
        issue(1'b0, 64'h200, '0, '0, 1'b0, 1'b1);
        t0 = cyc;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("timeout_resp_seen", LW'(seen), LW'(1));
        check("timeout_latency", LW'(cyc - t0), LW'(17));
        @(posedge clk);
        #1;
        drain();
        inj_mute = 1'b0;

        check("a_queue_empty", LW'(a_q.size()), LW'(0));
        check("d_queue_empty", LW'(d_q.size()), LW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
